// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake between the boot image source and instr_mem_loader.
//   ByteIn    : stream byte, driven by the source
//   ByteValid : ByteIn is valid this cycle, driven by the source
//   ByteReady : loader accepts a byte this cycle, driven by the loader
interface instr_mem_loader_if;
    logic [7:0] ByteIn;
    logic       ByteValid;
    logic       ByteReady;

    modport master (output ByteIn, output ByteValid, input ByteReady);
    modport slave  (input ByteIn, input ByteValid, output ByteReady);
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time loader and instruction read port for the single-cycle core.
// Receives a 16-bit word count N (high byte first) followed by 4*N bytes of
// big-endian instruction words, writes them to an internal RAM, and holds the
// datapath in reset until the whole program is in place.
//   CLK       : clock, all state changes on the rising edge
//   Reset     : synchronous, active-high
//   byte_if   : byte stream (ByteIn / ByteValid / ByteReady)
//   PC        : fetch address from the datapath
//   Instr     : instruction at PC, combinational; 0 (NOP) outside the RAM
//   CoreReset : datapath reset, high until the load completes
//   LoadDone  : program loaded, core running
//   LoadError : header word count larger than the RAM
module instr_mem_loader #(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned MEM_ADDR_WIDTH    = 8
) (
    input  logic                         CLK,
    input  logic                         Reset,
    instr_mem_loader_if.slave            byte_if,
    input  logic [INSTRUCTION_WIDTH-1:0] PC,
    output logic [INSTRUCTION_WIDTH-1:0] Instr,
    output logic                         CoreReset,
    output logic                         LoadDone,
    output logic                         LoadError
);

    localparam int unsigned DEPTH     = 2 ** MEM_ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned ASM_WIDTH = 24;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_LOAD,
        ST_RUN,
        ST_ERROR
    } state_e;

    state_e                         state_q, state_d;
    logic [7:0]                     n_hi_q, n_hi_d;
    logic [CNT_WIDTH-1:0]           word_cnt_q, word_cnt_d;
    logic [MEM_ADDR_WIDTH-1:0]      word_idx_q, word_idx_d;
    logic [1:0]                     byte_cnt_q, byte_cnt_d;
    logic [ASM_WIDTH-1:0]           asm_q, asm_d;

    logic                           ready_c;
    logic                           accept_c;
    logic                           last_word_c;
    logic [CNT_WIDTH-1:0]           hdr_n_c;
    logic                           mem_we_c;
    logic [INSTRUCTION_WIDTH-1:0]   mem_wdata_c;

    logic [INSTRUCTION_WIDTH-1:0]   mem_q [DEPTH];

    // Handshake and status decodes come straight from the state register.
    assign ready_c   = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) || (state_q == ST_LOAD);
    assign accept_c  = byte_if.ByteValid && ready_c;
    assign byte_if.ByteReady = ready_c;
    assign CoreReset = (state_q != ST_RUN);
    assign LoadDone  = (state_q == ST_RUN);
    assign LoadError = (state_q == ST_ERROR);

    assign hdr_n_c     = {n_hi_q, byte_if.ByteIn};
    assign last_word_c = (32'(word_idx_q) == (32'(word_cnt_q) - 32'd1));

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_HDR_HI;
            n_hi_q     <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_hi_q     <= n_hi_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // Next-state, assembly and write-port logic.
    always_comb begin
        state_d     = state_q;
        n_hi_d      = n_hi_q;
        word_cnt_d  = word_cnt_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        mem_we_c    = 1'b0;
        mem_wdata_c = INSTRUCTION_WIDTH'({asm_q, byte_if.ByteIn});

        case (state_q)
            ST_HDR_HI: begin
                if (accept_c) begin
                    n_hi_d  = byte_if.ByteIn;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept_c) begin
                    word_cnt_d = hdr_n_c;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    if (hdr_n_c == '0) begin
                        state_d = ST_RUN;
                    end else if (32'(hdr_n_c) > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    asm_d      = {asm_q[ASM_WIDTH-9:0], byte_if.ByteIn};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_c = 1'b1;
                        // Index holds on the final word so it never leaves the array range.
                        if (last_word_c) begin
                            state_d = ST_RUN;
                        end else begin
                            word_idx_d = word_idx_q + MEM_ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Instruction RAM write port; contents survive Reset.
    always_ff @(posedge CLK) begin
        if (!Reset && mem_we_c) begin
            mem_q[word_idx_q] <= mem_wdata_c;
        end
    end

    // Combinational fetch; addresses past the RAM read as NOP, byte offset ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^PC[1:0];

    always_comb begin
        Instr = '0;
        if (PC[INSTRUCTION_WIDTH-1:MEM_ADDR_WIDTH+2] == '0) begin
            Instr = mem_q[PC[MEM_ADDR_WIDTH+1:2]];
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: header handling, word assembly,
// stalls on ByteValid, error detection, reset mid-load and the fetch port.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int n_checks;
    int n_errors;
    int acc_cnt;
    int cyc_cnt;

    instr_mem_loader_if bus ();

    instr_mem_loader #(
        .INSTRUCTION_WIDTH (32),
        .MEM_ADDR_WIDTH    (8)
    ) dut (
        .CLK       (clk),
        .Reset     (rst),
        .byte_if   (bus),
        .PC        (pc),
        .Instr     (instr),
        .CoreReset (core_reset),
        .LoadDone  (load_done),
        .LoadError (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted bytes and elapsed cycles, sampled at the active edge.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (bus.ByteValid && bus.ByteReady && !rst) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one byte and let one active edge pass; optional random idle gap first.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            if (g > 0) begin
                bus.ByteValid = 1'b0;
                bus.ByteIn    = 8'hEE;
                repeat (g) @(negedge clk);
            end
        end
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[31:24], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[15:8],  gaps);
        send_byte(w[7:0],   gaps);
    endtask

    task automatic idle();
        bus.ByteValid = 1'b0;
        bus.ByteIn    = 8'h00;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.ByteValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        chk(tag, instr, exp);
    endtask

    function automatic logic [31:0] big_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    initial begin
        int a0;
        int c0;
        n_checks      = 0;
        n_errors      = 0;
        acc_cnt       = 0;
        cyc_cnt       = 0;
        pc            = 32'h0;
        bus.ByteIn    = 8'h00;
        bus.ByteValid = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready",  32'(bus.ByteReady), 32'd1);
        chk("rst_corerst", 32'(core_reset),   32'd1);
        chk("rst_done",   32'(load_done),     32'd0);
        chk("rst_err",    32'(load_error),    32'd0);

        // Two-word back-to-back load
        a0 = acc_cnt;
        c0 = cyc_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h12345678, 1'b0);
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'hDE, 1'b0);
        chk("b2b_corerst_before_last", 32'(core_reset), 32'd1);
        send_byte(8'hF0, 1'b0);
        chk("b2b_accepts", 32'(acc_cnt - a0), 32'd10);
        chk("b2b_cycles",  32'(cyc_cnt - c0), 32'd10);
        chk("b2b_done",    32'(load_done),    32'd1);
        chk("b2b_corerst", 32'(core_reset),   32'd0);
        chk("b2b_ready",   32'(bus.ByteReady), 32'd0);
        idle();
        fetch("b2b_pc0",   32'h0000_0000, 32'h12345678);
        fetch("b2b_pc4",   32'h0000_0004, 32'h9ABCDEF0);
        fetch("b2b_pc400", 32'h0000_0400, 32'h00000000);
        fetch("b2b_pc3",   32'h0000_0003, 32'h12345678);
        pc = 32'h0;

        // Reset from RUN, then an empty program
        do_reset();
        chk("rerun_corerst", 32'(core_reset), 32'd1);
        chk("rerun_done",    32'(load_done),  32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("n0_done",    32'(load_done),  32'd1);
        chk("n0_corerst", 32'(core_reset), 32'd0);
        idle();
        fetch("n0_nowrite", 32'h0, 32'h12345678);

        // N = DEPTH+1 is rejected; later bytes are ignored
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("err_flag",    32'(load_error),    32'd1);
        chk("err_ready",   32'(bus.ByteReady), 32'd0);
        chk("err_corerst", 32'(core_reset),    32'd1);
        a0 = acc_cnt;
        send_word(32'h55AA55AA, 1'b0);
        idle();
        chk("err_ignored", 32'(acc_cnt - a0), 32'd0);
        chk("err_sticky",  32'(load_error),   32'd1);
        fetch("err_nowrite", 32'h0, 32'h12345678);

        // N = DEPTH fills every word
        do_reset();
        a0 = acc_cnt;
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("full_inload", 32'(load_error), 32'd0);
        for (int i = 0; i < 256; i++) begin
            send_word(big_word(i), 1'b0);
        end
        idle();
        chk("full_accepts", 32'(acc_cnt - a0), 32'd1026);
        chk("full_done",    32'(load_done),    32'd1);
        fetch("full_w0",   32'h0000_0000, 32'h00FF5AC3);
        fetch("full_w1",   32'h0000_0004, 32'h01FE5BC3);
        fetch("full_w255", 32'h0000_03FC, 32'hFF00A5C3);

        // Three words with random ByteValid gaps
        do_reset();
        a0 = acc_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_word(32'hCAFEBABE, 1'b1);
        send_word(32'h01020304, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        idle();
        chk("gap_accepts", 32'(acc_cnt - a0), 32'd14);
        chk("gap_done",    32'(load_done),    32'd1);
        fetch("gap_w0",  32'h0000_0000, 32'hCAFEBABE);
        fetch("gap_w1",  32'h0000_0004, 32'h01020304);
        fetch("gap_w2",  32'h0000_0008, 32'hDEADBEEF);
        fetch("gap_w3_kept", 32'h0000_000C, 32'h03FC59C3);

        // Reset partway through word 1
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        do_reset();
        chk("mid_ready",   32'(bus.ByteReady), 32'd1);
        chk("mid_corerst", 32'(core_reset),    32'd1);
        chk("mid_done",    32'(load_done),     32'd0);
        fetch("mid_w0_kept", 32'h0, 32'h11223344);
        fetch("mid_w1_kept", 32'h4, 32'h01020304);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'hAABBCCDD, 1'b0);
        idle();
        chk("reload_done", 32'(load_done), 32'd1);
        fetch("reload_w0", 32'h0, 32'hAABBCCDD);
        fetch("reload_w1", 32'h4, 32'h01020304);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
